// File: rtl/enemy_pkg.sv
// enemy_pkg: definitions shared by the enemy sequencer, its datapath and the
// reusable frame divider.
//   seq_state_e  - sequencer state encoding (also exported on state_out)
//   dir_e        - direction codes chosen by the datapath during gen_move
//   SpritePixels - pixels written per enemy sprite draw
package enemy_pkg;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StIdle    = 3'd1,
    StGen     = 3'd2,
    StSettle  = 3'd3,
    StApply   = 3'd4,
    StReq     = 3'd5,
    StDraw    = 3'd6,
    StRelease = 3'd7
  } seq_state_e;

  typedef enum logic [2:0] {
    DirNoAction = 3'd0,
    DirAttack   = 3'd1,
    DirUp       = 3'd2,
    DirDown     = 3'd3,
    DirLeft     = 3'd4,
    DirRight    = 3'd5
  } dir_e;

  localparam int unsigned SpritePixels = 256;

  // Frame divider width covers MOVE_DIV up to 255.
  localparam int unsigned DivWidth = 8;
  // Settle counter width covers SETTLE_CYC up to 15.
  localparam int unsigned SettleWidth = 4;

endpackage

// File: rtl/frame_divider.sv
// frame_divider: counts enabled frame ticks and pulses terminal on the tick
// that completes a group of DIV ticks, clearing itself at the same time.
// Ports:
//   clock    - system clock
//   reset    - synchronous active-high reset, count returns to 0
//   enable   - one qualified tick this cycle
//   clear    - force the count back to 0
//   terminal - combinational: this enabled tick is the DIV-th one
module frame_divider #(
  parameter int unsigned DIV   = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam logic [WIDTH-1:0] Last = WIDTH'(DIV - 1);

  logic [WIDTH-1:0] count_q, count_d;

  assign terminal = enable && (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (clear || terminal) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/enemy_sequencer.sv
// enemy_sequencer: initiator of the enemy control protocol. Steps one enemy
// datapath through init / idle / gen_move / apply_move / draw, paces moves to
// every MOVE_DIV-th frame_tick, and holds the VGA port via vga_req/vga_gnt for
// the whole sprite draw.
// Ports:
//   clock, reset         - clock and synchronous active-high reset
//   start                - game running; low keeps the sequencer in IDLE
//   frame_tick           - one-cycle pulse per video frame
//   draw_done            - datapath level: sprite fully written
//   vga_gnt              - VGA arbiter grant
//   init, idle, gen_move,
//   apply_move, draw     - one-hot datapath phase strobes
//   vga_req              - VGA port request (REQ and DRAW)
//   busy                 - high in every state except IDLE
//   overrun              - sticky: frame_tick seen outside IDLE
//   error                - sticky: draw aborted by timeout
//   state_out            - current state encoding
// Build option: define ENEMY_DRAW_TIMEOUT_EN to abort a draw that runs for
// DRAW_TIMEOUT cycles without draw_done; otherwise DRAW waits forever and
// error is tied low.
module enemy_sequencer
  import enemy_pkg::*;
#(
  parameter int unsigned MOVE_DIV     = 2,
  parameter int unsigned SETTLE_CYC   = 2,
  parameter int unsigned DRAW_TIMEOUT = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       draw_done,
  input  logic       vga_gnt,
  output logic       init,
  output logic       idle,
  output logic       gen_move,
  output logic       apply_move,
  output logic       draw,
  output logic       vga_req,
  output logic       busy,
  output logic       overrun,
  output logic       error,
  output logic [2:0] state_out
);

  seq_state_e             state_q, state_d;
  logic [SettleWidth-1:0] settle_q, settle_d;
  logic                   overrun_q, overrun_d;
  logic                   div_en, div_term;
  logic                   draw_timeout;

  // Ticks only advance the divider while idle and running.
  assign div_en = (state_q == StIdle) && start && frame_tick;

  frame_divider #(
    .DIV   (MOVE_DIV),
    .WIDTH (DivWidth)
  ) u_frame_divider (
    .clock    (clock),
    .reset    (reset),
    .enable   (div_en),
    .clear    (1'b0),
    .terminal (div_term)
  );

`ifdef ENEMY_DRAW_TIMEOUT_EN
  localparam int unsigned ToWidth = $clog2(DRAW_TIMEOUT + 1);

  logic [ToWidth-1:0] to_cnt_q, to_cnt_d;
  logic               error_q, error_d;

  // to_cnt_q holds (draw cycles so far - 1); it rests at 0 outside DRAW.
  assign draw_timeout = (state_q == StDraw) && (to_cnt_q == ToWidth'(DRAW_TIMEOUT - 1));

  always_comb begin
    to_cnt_d = '0;
    if (state_q == StDraw) begin
      to_cnt_d = to_cnt_q + ToWidth'(1);
    end
  end

  // draw_done on the terminal cycle wins: no error recorded.
  always_comb begin
    error_d = error_q;
    if (draw_timeout && !draw_done) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error = error_q;
`else
  logic unused_draw_timeout;
  assign unused_draw_timeout = ^DRAW_TIMEOUT;
  assign draw_timeout        = 1'b0;
  assign error               = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StInit;
      settle_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        if (div_term) begin
          state_d = StGen;
        end
      end
      StGen: begin
        state_d  = StSettle;
        settle_d = SettleWidth'(SETTLE_CYC - 1);
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = StApply;
        end else begin
          settle_d = settle_q - SettleWidth'(1);
        end
      end
      StApply: state_d = StReq;
      StReq: begin
        if (vga_gnt) begin
          state_d = StDraw;
        end
      end
      // A dropped grant is ignored here; the port is held until RELEASE.
      StDraw: begin
        if (draw_done || draw_timeout) begin
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StInit;
    endcase
  end

  // Ticks outside IDLE are dropped and flagged.
  assign overrun_d = overrun_q | (frame_tick && (state_q != StIdle));

  // Outputs decode the state register only, so no input reaches them
  // combinationally.
  always_comb begin
    init       = 1'b0;
    idle       = 1'b0;
    gen_move   = 1'b0;
    apply_move = 1'b0;
    draw       = 1'b0;
    vga_req    = 1'b0;
    case (state_q)
      StInit:  init       = 1'b1;
      StIdle:  idle       = 1'b1;
      StGen:   gen_move   = 1'b1;
      StApply: apply_move = 1'b1;
      StReq:   vga_req    = 1'b1;
      StDraw: begin
        draw    = 1'b1;
        vga_req = 1'b1;
      end
      default: ;
    endcase
    busy      = (state_q != StIdle);
    overrun   = overrun_q;
    state_out = state_q;
  end

endmodule

// File: tb/tb_enemy_sequencer.sv
// Bench for enemy_sequencer: directed protocol scenarios followed by random
// start / frame_tick / grant / draw-length / reset traffic, all compared each
// cycle against a procedural model that walks the protocol over time.
module tb_enemy_sequencer;

  localparam int unsigned MoveDiv     = 2;
  localparam int unsigned SettleCyc   = 2;
  localparam int unsigned DrawTimeout = 300;

  logic       clock = 1'b0;
  logic       reset, start, frame_tick, draw_done, vga_gnt;
  logic       init, idle, gen_move, apply_move, draw, vga_req, busy, overrun, error;
  logic [2:0] state_out;

  enemy_sequencer #(
    .MOVE_DIV     (MoveDiv),
    .SETTLE_CYC   (SettleCyc),
    .DRAW_TIMEOUT (DrawTimeout)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .draw_done  (draw_done),
    .vga_gnt    (vga_gnt),
    .init       (init),
    .idle       (idle),
    .gen_move   (gen_move),
    .apply_move (apply_move),
    .draw       (draw),
    .vga_req    (vga_req),
    .busy       (busy),
    .overrun    (overrun),
    .error      (error),
    .state_out  (state_out)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers follow the published state encoding.
  int exp_state   = 0;
  bit exp_overrun = 1'b0;
  bit exp_error   = 1'b0;
  int m_ticks     = 0;
  bit m_abort     = 1'b0;

  // {init, idle, gen_move, apply_move, draw, vga_req, busy}
  function automatic logic [6:0] exp_outs(int s);
    logic [6:0] o;
    case (s)
      0:       o = 7'b1000001;
      1:       o = 7'b0100000;
      2:       o = 7'b0010001;
      4:       o = 7'b0001001;
      5:       o = 7'b0000011;
      6:       o = 7'b0000111;
      default: o = 7'b0000001;
    endcase
    return o;
  endfunction

  // Let one clock edge pass; account for reset and stray ticks.
  task automatic m_step();
    @(posedge clock);
    if (reset) begin
      m_abort     = 1'b1;
      exp_overrun = 1'b0;
      exp_error   = 1'b0;
      m_ticks     = 0;
    end else if (frame_tick && exp_state != 1) begin
      exp_overrun = 1'b1;
    end
  endtask

  task automatic model_pass();
    int n;
    exp_state = 0;
    m_step();
    if (m_abort) return;
    forever begin
      exp_state = 1;
      do begin
        m_step();
        if (m_abort) return;
        if (frame_tick && start) m_ticks++;
      end while (m_ticks < MoveDiv);
      m_ticks = 0;
      exp_state = 2;
      m_step();
      if (m_abort) return;
      for (int i = 0; i < SettleCyc; i++) begin
        exp_state = 3;
        m_step();
        if (m_abort) return;
      end
      exp_state = 4;
      m_step();
      if (m_abort) return;
      exp_state = 5;
      do begin
        m_step();
        if (m_abort) return;
      end while (!vga_gnt);
      exp_state = 6;
      n = 0;
      forever begin
        m_step();
        if (m_abort) return;
        n++;
        if (draw_done) break;
`ifdef ENEMY_DRAW_TIMEOUT_EN
        if (n == DrawTimeout) begin
          exp_error = 1'b1;
          break;
        end
`endif
      end
      exp_state = 7;
      m_step();
      if (m_abort) return;
    end
  endtask

  initial begin
    forever begin
      m_abort = 1'b0;
      model_pass();
    end
  end

  // ---------------- stimulus helpers ----------------
  bit chk_en   = 1'b0;
  bit rand_len = 1'b0;
  int draw_cnt = 0;
  int draw_len = 256;

  // Advance to the next falling edge, compare, then run the datapath model.
  task automatic cycle();
    @(negedge clock);
    if (chk_en) begin
      check_eq("state", 32'(state_out), exp_state);
      check_eq("outs", 32'({init, idle, gen_move, apply_move, draw, vga_req, busy}),
               32'(exp_outs(exp_state)));
      check_eq("overrun", 32'(overrun), 32'(exp_overrun));
      check_eq("error", 32'(error), 32'(exp_error));
    end
    if (draw) begin
      if (draw_cnt == 0 && rand_len) draw_len = $urandom_range(1, 20);
      draw_cnt++;
    end else begin
      draw_cnt = 0;
    end
    draw_done = draw && (draw_cnt >= draw_len);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic wait_state(string tag, int st, int limit);
    int k = 0;
    while (32'(state_out) != st && k < limit) begin
      cycle();
      k++;
    end
    check_eq(tag, 32'(state_out), st);
  endtask

  task automatic count_draw(string tag, int want);
    int n = 0;
    while (draw && n < 2000) begin
      n++;
      cycle();
    end
    check_eq(tag, n, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    reset      = 1'b1;
    start      = 1'b0;
    frame_tick = 1'b0;
    vga_gnt    = 1'b1;
    draw_done  = 1'b0;
    cycle();
    cycle();
    chk_en = 1'b1;

    // Release reset: INIT for one cycle, then IDLE.
    check_eq("init_c1", 32'(init), 1);
    reset = 1'b0;
    start = 1'b1;
    cycle();
    check_eq("idle_c2", 32'(idle), 1);
    pulse_tick();
    check_eq("no_gen_1st_tick", 32'(gen_move), 0);
    pulse_tick();
    check_eq("gen_2nd_tick", 32'(gen_move), 1);

    // Full sequence, grant always present, 256-cycle draw.
    k = 0;
    while (!apply_move && k < 20) begin
      cycle();
      k++;
    end
    check_eq("gen_to_apply", k, 3);
    wait_state("reach_draw", 6, 20);
    count_draw("draw_256", 256);
    check_eq("release", 32'(state_out), 7);
    cycle();
    check_eq("back_idle", 32'(idle), 1);

    // Grant withheld for 10 REQ cycles.
    draw_len = 30;
    vga_gnt  = 1'b0;
    pulse_tick();
    pulse_tick();
    wait_state("reach_req", 5, 20);
    k = 0;
    while (32'(state_out) == 5 && k < 50) begin
      k++;
      check_eq("no_draw_in_req", 32'(draw), 0);
      if (k == 10) vga_gnt = 1'b1;
      cycle();
    end
    check_eq("req_wait", k, 10);
    check_eq("draw_after_gnt", 32'(state_out), 6);

    // Tick during DRAW, grant dropped mid-draw.
    pulse_tick();
    vga_gnt = 1'b0;
    check_eq("overrun_set", 32'(overrun), 1);
    wait_state("idle_after_ovr", 1, 100);
    check_eq("overrun_sticky", 32'(overrun), 1);
    pulse_tick();
    check_eq("no_gen_after_ovr", 32'(gen_move), 0);
    pulse_tick();
    check_eq("gen_after_ovr", 32'(gen_move), 1);

    // Reset in the middle of a draw.
    vga_gnt  = 1'b1;
    draw_len = 200;
    wait_state("reach_draw2", 6, 20);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    check_eq("rst_init", 32'(init), 1);
    check_eq("rst_req", 32'(vga_req), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_state", 32'(state_out), 0);
    reset = 1'b0;

    // Random traffic.
    rand_len = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 4) == 0);
      vga_gnt    = $urandom_range(0, 1) != 0;
      reset      = ($urandom_range(0, 599) == 0);
      cycle();
    end
    reset      = 1'b0;
    frame_tick = 1'b0;
    rand_len   = 1'b0;

`ifdef ENEMY_DRAW_TIMEOUT_EN
    // Draw that never completes, then one completing on the terminal cycle.
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b1;
      cycle();
      reset    = 1'b0;
      start    = 1'b1;
      vga_gnt  = 1'b1;
      draw_len = (pass == 0) ? 100000 : DrawTimeout;
      cycle();
      pulse_tick();
      pulse_tick();
      wait_state("to_reach_draw", 6, 20);
      count_draw("to_draw_len", DrawTimeout);
      check_eq("to_release", 32'(state_out), 7);
      check_eq("to_error", 32'(error), (pass == 0) ? 1 : 0);
    end
`endif

    cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
